tg_bus_capture: RTL

TG_BUS_CAPTURE -- requirements
Module: tg_bus_capture

---
 rtl/tg_bus_pkg.sv | 27 ++
 rtl/tg_bus_fifo.sv | 66 ++++++
 rtl/tg_bus_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tg_bus_pkg.sv
// Shared types and limits for the CPU bus write-capture block.
// Holds the FIFO entry layout and the legal ranges for the synchronizer depth
// and the capture window size.
package tg_bus_pkg;

  localparam int ADDR_W          = 21;
  localparam int DATA_W          = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;
  localparam int WIN_BITS_MIN    = 1;
  localparam int WIN_BITS_MAX    = 12;

  // One captured write. The offset field is sized for the largest window;
  // smaller windows zero-fill the upper offset bits.
  typedef struct packed {
    logic [WIN_BITS_MAX-1:0] addr;
    logic [DATA_W-1:0]       data;
  } fifo_entry_t;

  // True when addr falls in the 2^win_bits byte window that starts at base.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int                win_bits);
    return (addr >> win_bits) == (base >> win_bits);
  endfunction

endpackage

// File: rtl/tg_bus_fifo.sv
// Small valid/ready FIFO for captured bus writes.
// Pointers wrap modulo DEPTH (a power of two); a separate count gives
// full/empty. A push into a full FIFO with no pop that cycle is dropped and
// reported on drop_o. The head is forced to zero while the FIFO is empty.
module tg_bus_fifo
  import tg_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fifo_entry_t              push_entry_i,
  output logic                     drop_o,
  input  logic                     ready_i,
  output logic                     valid_o,
  output fifo_entry_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  fifo_entry_t   mem_q [DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic push_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = !empty && ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;

  assign valid_o = !empty;
  assign count_o = count_q;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push_ok) count_q <= count_q - (PW+1)'(1);
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; count/valid gating keeps stale
  // contents from ever reaching the outputs.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/tg_bus_capture.sv
// Captures CPU bus writes that land in a fixed address window and queues them
// for a downstream register block.
// Strobes are synchronized through SYNC_STAGES flops and address/data travel
// through an equal-depth pipeline so all three stay aligned. A write is taken
// from the shadow register when synced WEn rises, provided the address is in
// the window and no read strobe was seen during the low phase.
// Optional feature: define TG_BUS_RD_EVENT_EN to add RD_EVT/RD_ADDR, a one-cycle
// pulse reporting in-window reads.
module tg_bus_capture
  import tg_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] WIN_BASE    = 21'h0FFF00,
  parameter int                WIN_BITS    = 8,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ADDR_W-1:0]             TG_A,
  input  logic [DATA_W-1:0]             CPU_DATO,
  input  logic                          TG_WEn,
  input  logic                          TG_OEn,
  output logic                          WR_VALID,
  input  logic                          WR_READY,
  output logic [WIN_BITS-1:0]           WR_ADDR,
  output logic [DATA_W-1:0]             WR_DATA,
  output logic                          OVF,
  input  logic                          OVF_CLR,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LVL
`ifdef TG_BUS_RD_EVENT_EN
  ,
  output logic                          RD_EVT,
  output logic [WIN_BITS-1:0]           RD_ADDR
`endif
);

  // Synchronizer chains and the aligned address/data pipeline.
  logic [SYNC_STAGES-1:0] wen_sync_q;
  logic [SYNC_STAGES-1:0] oen_sync_q;
  logic [SYNC_STAGES-1:0] real_q;     // marks stages holding post-reset samples
  logic [ADDR_W-1:0]      a_pipe_q [SYNC_STAGES];
  logic [DATA_W-1:0]      d_pipe_q [SYNC_STAGES];

  logic              wen_s;
  logic              oen_s;
  logic              real_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;

  assign wen_s  = wen_sync_q[SYNC_STAGES-1];
  assign oen_s  = oen_sync_q[SYNC_STAGES-1];
  assign real_s = real_q[SYNC_STAGES-1];
  assign addr_s = a_pipe_q[SYNC_STAGES-1];
  assign data_s = d_pipe_q[SYNC_STAGES-1];

  // Shift strobes, address and data through matching-depth register chains.
  // NOTE: clocked blocks use non-blocking (<=) so every flop in a chain samples
  // the value its predecessor held before the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wen_sync_q <= '1;
      oen_sync_q <= '1;
      real_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_pipe_q[i] <= '0;
        d_pipe_q[i] <= '0;
      end
    end else begin
      wen_sync_q  <= {wen_sync_q[SYNC_STAGES-2:0], TG_WEn};
      oen_sync_q  <= {oen_sync_q[SYNC_STAGES-2:0], TG_OEn};
      real_q      <= {real_q[SYNC_STAGES-2:0], 1'b1};
      a_pipe_q[0] <= TG_A;
      d_pipe_q[0] <= CPU_DATO;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_pipe_q[i] <= a_pipe_q[i-1];
        d_pipe_q[i] <= d_pipe_q[i-1];
      end
    end
  end

  // Write-phase tracking.
  logic              wen_prev_q;
  logic              prev_real_q;
  logic              in_low_q,  in_low_d;
  logic              rd_seen_q, rd_seen_d;
  logic [ADDR_W-1:0] shadow_addr_q, shadow_addr_d;
  logic [DATA_W-1:0] shadow_data_q, shadow_data_d;

  logic wen_fall;
  logic wen_rise;
  logic push;

  // A low phase only counts if the preceding high came from a real sample, so
  // a strobe already low at reset release never completes into a push.
  assign wen_fall = prev_real_q && wen_prev_q && !wen_s;
  assign wen_rise = in_low_q && wen_s;
  assign push     = wen_rise && !rd_seen_q &&
                    in_window(shadow_addr_q, WIN_BASE, WIN_BITS);

  // Next state for the shadow register and low-phase flags.
  // NOTE: every _d gets its default first; a branch that skipped an assignment
  // would otherwise infer a latch.
  always_comb begin
    in_low_d      = in_low_q;
    rd_seen_d     = rd_seen_q;
    shadow_addr_d = shadow_addr_q;
    shadow_data_d = shadow_data_q;
    if (!wen_s) begin
      shadow_addr_d = addr_s;
      shadow_data_d = data_s;
    end
    if (wen_fall) begin
      in_low_d  = 1'b1;
      rd_seen_d = !oen_s;
    end else if (in_low_q) begin
      if (wen_s) in_low_d  = 1'b0;
      else       rd_seen_d = rd_seen_q || !oen_s;
    end
  end

  // Register the shadow and low-phase state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wen_prev_q    <= 1'b1;
      prev_real_q   <= 1'b0;
      in_low_q      <= 1'b0;
      rd_seen_q     <= 1'b0;
      shadow_addr_q <= '0;
      shadow_data_q <= '0;
    end else begin
      wen_prev_q    <= wen_s;
      prev_real_q   <= real_s;
      in_low_q      <= in_low_d;
      rd_seen_q     <= rd_seen_d;
      shadow_addr_q <= shadow_addr_d;
      shadow_data_q <= shadow_data_d;
    end
  end

  // Write queue.
  fifo_entry_t push_entry;
  fifo_entry_t head_entry;
  logic        fifo_drop;

  assign push_entry.addr = WIN_BITS_MAX'(shadow_addr_q[WIN_BITS-1:0]);
  assign push_entry.data = shadow_data_q;

  tg_bus_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (CLK),
    .rst          (RST),
    .push_i       (push),
    .push_entry_i (push_entry),
    .drop_o       (fifo_drop),
    .ready_i      (WR_READY),
    .valid_o      (WR_VALID),
    .head_o       (head_entry),
    .count_o      (FIFO_LVL)
  );

  assign WR_ADDR = WIN_BITS'(head_entry.addr);
  assign WR_DATA = head_entry.data;

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop)    ovf_d = 1'b1;
    else if (OVF_CLR) ovf_d = 1'b0;
  end

  // Register the overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign OVF = ovf_q;

`ifdef TG_BUS_RD_EVENT_EN
  logic                oen_prev_q;
  logic                rd_evt_q;
  logic [WIN_BITS-1:0] rd_addr_q;
  logic                rd_fall;

  assign rd_fall = prev_real_q && oen_prev_q && !oen_s &&
                   in_window(addr_s, WIN_BASE, WIN_BITS);

  // Pulse once on each synced read strobe falling edge inside the window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oen_prev_q <= 1'b1;
      rd_evt_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      oen_prev_q <= oen_s;
      rd_evt_q   <= rd_fall;
      if (rd_fall) rd_addr_q <= addr_s[WIN_BITS-1:0];
    end
  end

  assign RD_EVT  = rd_evt_q;
  assign RD_ADDR = rd_addr_q;
`endif

endmodule
